// File: rtl/modexp_pkg.sv
// Shared definitions for the modular-exponentiation sequencer: FSM state codes,
// operand/destination select encodings and the per-state operand table.
package modexp_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned NUM_WORDS_DEF  = 32;
    localparam int unsigned CNT_W_DEF      = 12;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_PRE_M = 3'd2;
    localparam logic [2:0] ST_PRE_A = 3'd3;
    localparam logic [2:0] ST_SQR   = 3'd4;
    localparam logic [2:0] ST_MUL   = 3'd5;
    localparam logic [2:0] ST_POST  = 3'd6;
    localparam logic [2:0] ST_FIN   = 3'd7;

    // MonPro operand sources
    localparam logic [1:0] SEL_R2   = 2'd0;
    localparam logic [1:0] SEL_MBAR = 2'd1;
    localparam logic [1:0] SEL_ACC  = 2'd2;
    localparam logic [1:0] SEL_ONE  = 2'd3;

    // MonPro result destinations
    localparam logic DST_ACC  = 1'b0;
    localparam logic DST_MBAR = 1'b1;

    typedef struct packed {
        logic [1:0] a_sel;
        logic [1:0] b_sel;
        logic       dst_sel;
    } op_sel_t;

    // Operand/destination selects for the MonPro issued from a given op state.
    function automatic op_sel_t op_sel(input logic [2:0] st);
        op_sel_t s;
        s = '{a_sel: SEL_ACC, b_sel: SEL_ACC, dst_sel: DST_ACC};
        case (st)
            ST_PRE_M: s = '{a_sel: SEL_R2,  b_sel: SEL_MBAR, dst_sel: DST_MBAR};
            ST_PRE_A: s = '{a_sel: SEL_R2,  b_sel: SEL_ONE,  dst_sel: DST_ACC};
            ST_MUL:   s = '{a_sel: SEL_ACC, b_sel: SEL_MBAR, dst_sel: DST_ACC};
            ST_POST:  s = '{a_sel: SEL_ACC, b_sel: SEL_ONE,  dst_sel: DST_ACC};
            default:  s = '{a_sel: SEL_ACC, b_sel: SEL_ACC,  dst_sel: DST_ACC};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/exp_bit_scanner.sv
// Exponent register file with bit select by scan index.
// With SKIP_LEADING_ZEROS_EN defined it also tracks whether a 1 bit has been
// scanned yet and flags leading zero bits that need no squaring.
module exp_bit_scanner
    import modexp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned NUM_WORDS  = NUM_WORDS_DEF,
    localparam int unsigned EXP_BITS  = DATA_WIDTH * NUM_WORDS,
    localparam int unsigned IDX_W     = $clog2(EXP_BITS),
    localparam int unsigned WC_W      = $clog2(NUM_WORDS)
) (
    input  logic                  clk_i,
`ifdef SKIP_LEADING_ZEROS_EN
    input  logic                  rst_ni,
    input  logic                  seen_clr_i,
    input  logic                  seen_set_i,
    output logic                  skip_o,
`endif
    input  logic                  we_i,
    input  logic [WC_W-1:0]       waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [IDX_W-1:0]      bit_idx_i,
    output logic                  bit_o
);

    localparam int unsigned BIT_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] exp_q [NUM_WORDS];
    logic [DATA_WIDTH-1:0] word;

    // Exponent storage; only written during LOAD, contents need no reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            exp_q[waddr_i] <= wdata_i;
        end
    end

    // Upper index bits pick the word, lower bits the bit within it.
    always_comb begin
        word  = exp_q[bit_idx_i[IDX_W-1:BIT_W]];
        bit_o = word[bit_idx_i[BIT_W-1:0]];
    end

`ifdef SKIP_LEADING_ZEROS_EN
    logic seen_one_q;

    // Remember the first 1 bit of the scan; cleared on each new start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seen_one_q <= 1'b0;
        end else if (seen_clr_i) begin
            seen_one_q <= 1'b0;
        end else if (seen_set_i) begin
            seen_one_q <= 1'b1;
        end
    end

    assign skip_o = !seen_one_q && !bit_o;
`endif

endmodule

// File: rtl/modexp_sequencer.sv
// Control FSM for C = M^E mod N on a shared word-serial Montgomery multiplier.
// Loads E word-serially, then issues to-Montgomery, a left-to-right
// square-and-multiply scan and from-Montgomery over an mm_start/mm_done handshake.
// Optional macro: SKIP_LEADING_ZEROS_EN (skip squarings above the top 1 bit of E).
module modexp_sequencer
    import modexp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned NUM_WORDS  = NUM_WORDS_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF,
    localparam int unsigned EXP_BITS  = DATA_WIDTH * NUM_WORDS,
    localparam int unsigned IDX_W     = $clog2(EXP_BITS),
    localparam int unsigned WC_W      = $clog2(NUM_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [DATA_WIDTH-1:0] e_word_i,
    input  logic                  e_valid_i,
    output logic                  mm_start_o,
    output logic [1:0]            mm_a_sel_o,
    output logic [1:0]            mm_b_sel_o,
    output logic                  mm_dst_sel_o,
    input  logic                  mm_done_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_W-1:0]      mul_count_o
);

    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_BITS - 1);
    localparam logic [WC_W-1:0]  WC_LAST = WC_W'(NUM_WORDS - 1);

    logic [2:0]       state_q, state_d;
    logic             issue_q, issue_d;   // op state entered, MonPro not yet launched
    logic [WC_W-1:0]  word_cnt_q, word_cnt_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] mul_count_q, mul_count_d;
    logic             mm_start_q, mm_start_d;
    logic [1:0]       a_sel_q, a_sel_d, b_sel_q, b_sel_d;
    logic             dst_q, dst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic    exp_we;
    logic    cur_bit;
    logic    skip_now;
    op_sel_t sel_now;

`ifdef SKIP_LEADING_ZEROS_EN
    logic skip;
    logic seen_clr;
    logic seen_set;

    assign skip_now = (state_q == ST_SQR) && skip;
    assign seen_clr = (state_q == ST_IDLE) && start_i && !abort_i;
    assign seen_set = issue_q && (state_q == ST_SQR) && !skip && !abort_i;
`else
    assign skip_now = 1'b0;
`endif

    exp_bit_scanner #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_WORDS  (NUM_WORDS)
    ) u_scanner (
        .clk_i      (clk_i),
`ifdef SKIP_LEADING_ZEROS_EN
        .rst_ni     (rst_ni),
        .seen_clr_i (seen_clr),
        .seen_set_i (seen_set),
        .skip_o     (skip),
`endif
        .we_i       (exp_we),
        .waddr_i    (word_cnt_q),
        .wdata_i    (e_word_i),
        .bit_idx_i  (bit_idx_q),
        .bit_o      (cur_bit)
    );

    assign sel_now = op_sel(state_q);

    // Next-state logic: load, launch one MonPro per op state, advance on mm_done.
    always_comb begin
        state_d     = state_q;
        issue_d     = issue_q;
        word_cnt_d  = word_cnt_q;
        bit_idx_d   = bit_idx_q;
        mul_count_d = mul_count_q;
        mm_start_d  = 1'b0;
        a_sel_d     = a_sel_q;
        b_sel_d     = b_sel_q;
        dst_d       = dst_q;
        done_d      = 1'b0;
        exp_we      = 1'b0;

        if (abort_i) begin
            state_d = ST_IDLE;
            issue_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d     = ST_LOAD;
                        word_cnt_d  = '0;
                        mul_count_d = '0;
                        bit_idx_d   = IDX_TOP;
                    end
                end
                ST_LOAD: begin
                    if (e_valid_i) begin
                        exp_we     = 1'b1;
                        word_cnt_d = word_cnt_q + WC_W'(1);
                        if (word_cnt_q == WC_LAST) begin
                            state_d = ST_PRE_M;
                            issue_d = 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    if (issue_q) begin
                        if (skip_now) begin
                            // Leading zero: no squaring needed, just move the scan down.
                            if (bit_idx_q == '0) begin
                                state_d = ST_POST;
                            end else begin
                                bit_idx_d = bit_idx_q - IDX_W'(1);
                            end
                        end else begin
                            issue_d     = 1'b0;
                            mm_start_d  = 1'b1;
                            mul_count_d = mul_count_q + CNT_W'(1);
                            a_sel_d     = sel_now.a_sel;
                            b_sel_d     = sel_now.b_sel;
                            dst_d       = sel_now.dst_sel;
                        end
                    end else if (mm_done_i) begin
                        issue_d = 1'b1;
                        case (state_q)
                            ST_PRE_M: state_d = ST_PRE_A;
                            ST_PRE_A: state_d = ST_SQR;
                            ST_SQR: begin
                                if (cur_bit) begin
                                    state_d = ST_MUL;
                                end else if (bit_idx_q == '0) begin
                                    state_d = ST_POST;
                                end else begin
                                    bit_idx_d = bit_idx_q - IDX_W'(1);
                                end
                            end
                            ST_MUL: begin
                                if (bit_idx_q == '0) begin
                                    state_d = ST_POST;
                                end else begin
                                    bit_idx_d = bit_idx_q - IDX_W'(1);
                                    state_d   = ST_SQR;
                                end
                            end
                            default: begin
                                state_d = ST_FIN;
                                issue_d = 1'b0;
                                done_d  = 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            issue_q     <= 1'b0;
            word_cnt_q  <= '0;
            bit_idx_q   <= IDX_TOP;
            mul_count_q <= '0;
            mm_start_q  <= 1'b0;
            a_sel_q     <= SEL_R2;
            b_sel_q     <= SEL_R2;
            dst_q       <= DST_ACC;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_q     <= issue_d;
            word_cnt_q  <= word_cnt_d;
            bit_idx_q   <= bit_idx_d;
            mul_count_q <= mul_count_d;
            mm_start_q  <= mm_start_d;
            a_sel_q     <= a_sel_d;
            b_sel_q     <= b_sel_d;
            dst_q       <= dst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign mm_start_o   = mm_start_q;
    assign mm_a_sel_o   = a_sel_q;
    assign mm_b_sel_o   = b_sel_q;
    assign mm_dst_sel_o = dst_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign mul_count_o  = mul_count_q;

endmodule

// File: tb/tb_modexp_sequencer.sv
// Scoreboard bench for modexp_sequencer: the driver pushes the expected MonPro
// schedule (derived from E by the square-and-multiply rule) and final op count;
// a monitor pops and compares on every mm_start / done. A multiplier model
// answers each mm_start with mm_done after a fixed or random latency.
module tb_modexp_sequencer;
    import modexp_pkg::*;

    localparam int DW = 32;
    localparam int NW = 32;
    localparam int CW = 12;
    localparam int EB = DW * NW;

`ifdef SKIP_LEADING_ZEROS_EN
    localparam int E1_CNT = 5;
    localparam int E5_CNT = 8;
`else
    localparam int E1_CNT = 1028;
    localparam int E5_CNT = 1029;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          e_valid = 1'b0;
    logic          mm_done = 1'b0;
    logic [DW-1:0] e_word = '0;
    logic          mm_start;
    logic [1:0]    a_sel;
    logic [1:0]    b_sel;
    logic          dst;
    logic          busy;
    logic          done;
    logic [CW-1:0] mul_count;

    modexp_sequencer #(
        .DATA_WIDTH (DW),
        .NUM_WORDS  (NW),
        .CNT_W      (CW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .abort_i      (abort),
        .e_word_i     (e_word),
        .e_valid_i    (e_valid),
        .mm_start_o   (mm_start),
        .mm_a_sel_o   (a_sel),
        .mm_b_sel_o   (b_sel),
        .mm_dst_sel_o (dst),
        .mm_done_i    (mm_done),
        .busy_o       (busy),
        .done_o       (done),
        .mul_count_o  (mul_count)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail = 0;
    int            lat_fixed = 5;
    int            mon_issued = 0;
    int            last_count = 0;
    int            exp_total = 0;
    logic [DW-1:0] e_words [NW];
    logic [4:0]    exp_ops [$];
    int            exp_cnt [$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Expected MonPro schedule for the exponent in e_words.
    task automatic build_expect();
        int n;
        bit b;
`ifdef SKIP_LEADING_ZEROS_EN
        bit seen;
        seen = 1'b0;
`endif
        exp_ops.push_back({SEL_R2, SEL_MBAR, DST_MBAR});
        exp_ops.push_back({SEL_R2, SEL_ONE, DST_ACC});
        n = 2;
        for (int i = EB - 1; i >= 0; i--) begin
            b = e_words[i / DW][i % DW];
`ifdef SKIP_LEADING_ZEROS_EN
            if (!seen && !b) continue;
            seen = seen | b;
`endif
            exp_ops.push_back({SEL_ACC, SEL_ACC, DST_ACC});
            n++;
            if (b) begin
                exp_ops.push_back({SEL_ACC, SEL_MBAR, DST_ACC});
                n++;
            end
        end
        exp_ops.push_back({SEL_ACC, SEL_ONE, DST_ACC});
        n++;
        exp_cnt.push_back(n);
        exp_total = n;
    endtask

    // Monitor: compare every launched op and every completion against the scoreboard.
    initial begin : monitor
        logic [4:0] want;
        forever begin
            @(negedge clk);
            if (mm_start) begin
                mon_issued++;
                if (exp_ops.size() == 0) begin
                    check("unexpected_mm_start", 1, 0);
                end else begin
                    want = exp_ops.pop_front();
                    check("op_sel", {a_sel, b_sel, dst}, want);
                    check("mul_count_at_start", mul_count, mon_issued);
                end
            end
            if (done) begin
                last_count = int'(mul_count);
                if (exp_cnt.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    check("final_mul_count", mul_count, exp_cnt.pop_front());
                end
            end
        end
    end

    // Multiplier model: one mm_done per mm_start; dropped if reset intervenes.
    initial begin : mm_model
        logic [4:0] held;
        int         lat;
        bit         live;
        forever begin
            @(negedge clk);
            if (rst_n && mm_start) begin
                held = {a_sel, b_sel, dst};
                lat  = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 5));
                live = 1'b1;
                for (int k = 0; k < lat; k++) begin
                    @(posedge clk);
                    if (!rst_n) live = 1'b0;
                end
                if (live && rst_n) begin
                    #1 mm_done = 1'b1;
                    @(negedge clk);
                    if (busy) check("sel_hold", {a_sel, b_sel, dst}, held);
                    @(posedge clk);
                    #1 mm_done = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_run(input bit gaps, input bit check_lat, input bit start_during);
        build_expect();
        mon_issued = 0;
        @(posedge clk);
        #1;
        start   = 1'b1;
        e_valid = 1'b1;          // ignored outside LOAD
        e_word  = $urandom;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < NW; i++) begin
            if (gaps) begin
                e_valid = 1'b0;
                e_word  = $urandom;
                @(posedge clk);
                #1;
            end
            e_word  = e_words[i];
            e_valid = 1'b1;
            start   = start_during;
            @(posedge clk);
            #1;
        end
        e_valid = 1'b0;
        start   = 1'b0;
        e_word  = $urandom;
        if (check_lat) begin
            @(negedge clk);
            check("first_start_early", mm_start, 0);
            @(negedge clk);
            check("first_start_latency", mm_start, 1);
        end
        check("busy_in_run", busy, 1);
    endtask

    task automatic wait_done(input int limit);
        bit got;
        got = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check("run_completes", got, 1);
        if (got) begin
            @(negedge clk);
            check("done_one_cycle", done, 0);
            check("idle_after_done", busy, 0);
            check("ops_consumed", exp_ops.size(), 0);
            check("count_held", mul_count, exp_total);
        end else begin
            exp_ops.delete();
            exp_cnt.delete();
        end
    endtask

    task automatic set_words(input int mode);
        for (int i = 0; i < NW; i++) begin
            case (mode)
                0: e_words[i] = '0;
                1: e_words[i] = '1;
                2: e_words[i] = DW'(i);
                default: e_words[i] = $urandom;
            endcase
        end
    endtask

    initial begin : driver
        bit found;
        int sqr_n;
        int frozen;

        #2 rst_n = 1'b0;
        #1;
        check("rst_mm_start", mm_start, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sels", {a_sel, b_sel, dst}, 0);
        check("rst_mul_count", mul_count, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // E = 1, fixed 5-cycle multiplier latency
        lat_fixed = 5;
        set_words(0);
        e_words[0] = 32'h1;
        start_run(1'b0, 1'b1, 1'b0);
        wait_done(20000);
        check("e1_count", last_count, E1_CNT);

        // E = 5, random latency
        lat_fixed = 0;
        set_words(0);
        e_words[0] = 32'h5;
        start_run(1'b0, 1'b0, 1'b0);
        wait_done(20000);
        check("e5_count", last_count, E5_CNT);

        // E = all ones
        set_words(1);
        start_run(1'b0, 1'b0, 1'b0);
        wait_done(30000);
        check("ones_count", last_count, 2051);

        // words = index, e_valid every other cycle, start held during LOAD
        set_words(2);
        start_run(1'b1, 1'b1, 1'b1);
        wait_done(20000);

        // random E
        set_words(3);
        start_run(1'b0, 1'b0, 1'b0);
        wait_done(20000);

        // abort and start together in IDLE: abort wins
        @(posedge clk);
        #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_beats_start", busy, 0);

        // abort during the 100th SQR wait
        lat_fixed = 5;
        set_words(3);
        e_words[NW-1][DW-1] = 1'b1;
        start_run(1'b0, 1'b0, 1'b0);
        found = 1'b0;
        sqr_n = 0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (mm_start && a_sel == SEL_ACC && b_sel == SEL_ACC) begin
                sqr_n++;
                if (sqr_n == 100) begin
                    found = 1'b1;
                    break;
                end
            end
        end
        check("reach_100th_sqr", found, 1);
        @(posedge clk);
        #1 abort = 1'b1;
        frozen = mon_issued;
        @(posedge clk);
        #1 abort = 1'b0;
        exp_ops.delete();
        exp_cnt.delete();
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_mm_start", mm_start, 0);
        check("abort_done", done, 0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) check("abort_quiet", {done, busy}, 0);
        end
        check("abort_count_frozen", mul_count, frozen);
        set_words(3);
        start_run(1'b0, 1'b0, 1'b0);
        wait_done(20000);

        // asynchronous reset mid-MUL
        set_words(3);
        e_words[NW-1][DW-1] = 1'b1;
        start_run(1'b0, 1'b0, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (mm_start && a_sel == SEL_ACC && b_sel == SEL_MBAR) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_mul", found, 1);
        rst_n = 1'b0;
        #1;
        check("arst_mm_start", mm_start, 0);
        check("arst_busy", busy, 0);
        check("arst_mul_count", mul_count, 0);
        check("arst_sels", {a_sel, b_sel, dst}, 0);
        exp_ops.delete();
        exp_cnt.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        lat_fixed = 0;
        set_words(3);
        start_run(1'b0, 1'b1, 1'b0);
        wait_done(20000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
